uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver that pairs with the SoC's existing 7-bit UART transmitter. It deserialises 8N1 frames (start bit, 8 data bits LSB first, 1 stop bit) from the asynchronous `rx` pin and keeps the low 7 data bits in a holding register. A valid/rd handshake passes the byte to the host side, with framing-error and overrun reporting. Bit timing is generated internally from a clocks-per-bit parameter; there is no external baud strobe.

Parameters:
CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range ≥ 4
HALF_BIT, CLKS_PER_BIT/2, cycles from start-bit detection to the start-bit sample point (integer division)

Ports:
clk  input  1  system clock
res  input  1  reset, asynchronous, active-high
rx  input  1  serial line, asynchronous to clk, idle high
data  output  7  received byte bits [6:0], held until the next good frame
valid  output  1  level; high while `data` holds an unread byte
rd  input  1  host read strobe; clears `valid` (and `overrun`) on the next edge
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky; a new byte loaded while `valid` was high and `rd` was low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async, res=1): state=IDLE, sync flops=1, shift reg=0, bit_cnt=0, baud counter=0, data=0, valid=0, frame_err=0, overrun=0, busy=0.
- rx passes through a 2-FF synchroniser (reset value 1). All decisions use the synchronised value `rxs`.
- FSM states:
  - IDLE: when rxs==0, go to START and clear the counter.
  - START: count to HALF_BIT-1, then sample. If rxs==0, go to DATA with counter=0 and bit_cnt=0. If rxs==1, treat as a glitch and return to IDLE with no flags.
  - DATA: count to CLKS_PER_BIT-1, then sample and shift in LSB first (shreg = {rxs, shreg[7:1]}), bit_cnt+1. After the 8th sample, go to STOP.
  - STOP: count to CLKS_PER_BIT-1, then sample.
    - rxs==1: data ← shreg[6:0] and valid ← 1. If valid was already 1 and rd==0 that cycle, overrun ← 1. Go to IDLE.
    - rxs==0: frame_err pulses for 1 cycle, data and valid are unchanged, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. This stops a held-low line from retriggering.
- shreg[7] is discarded; the transmitter always sends 0 there, and a 1 is not flagged.
- Stop is sampled mid-bit, so the block is back in IDLE half a bit early and can accept back-to-back frames.
- Timing: let t = the cycle the FSM enters START. The start sample is at t+HALF_BIT. Data bit k is sampled at t+HALF_BIT+(k+1)·CLKS_PER_BIT. The stop sample is at t+HALF_BIT+9·CLKS_PER_BIT, and valid/data are visible on the following cycle.
- rd while valid==0 has no effect.
- rd on the same cycle as a new load: valid stays 1 with the new data, overrun is not set.
- rd on any other cycle clears valid and overrun next cycle.
- Reset mid-frame: the block returns immediately to reset values. A partial frame is never loaded.
- Counters are sized $clog2(CLKS_PER_BIT). No wrap beyond the terminal counts.

Test Plan:
- CLKS_PER_BIT=16, send 0x55 (bits 1010101 plus bit7=0) with an ideal 8N1 frame. Required: valid rises at stop sample+1 (±2 clk window), data=7'h55, frame_err never pulses, busy=0 after.
- Send 0x41 then 0x7E back-to-back (no idle gap), pulsing rd after each valid. Required: data=7'h41, then 7'h7E, and overrun=0.
- Send 0x12 with no rd, then 0x34. Required: data=7'h34, valid=1, overrun=1. Then rd gives valid=0 and overrun=0 on the next cycle.
- Send a frame with stop bit=0, data 0x33, with previous data 0x12. Required: one frame_err pulse, data stays 7'h12, FSM waits in BREAK until rx high, then correctly receives 0x21.
- Drive a 5-cycle low glitch on idle rx. Required: FSM returns to IDLE at start sample, no valid, no frame_err.
- Assert res at bit 4 of a frame, release, then send 0x6A. Required: all outputs at reset values while res=1, then data=7'h6A and valid=1 only for the new frame.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a valid/rd handshake, keeping the low 7 data
// bits of each frame. Bit timing comes from an internal counter driven by
// CLKS_PER_BIT, so no external baud strobe is needed.
//
// Ports:
//   clk        system clock
//   res        asynchronous active-high reset
//   rx         serial line (asynchronous to clk, idle high)
//   rd         host read strobe; clears valid/overrun on the next edge
//   data[6:0]  last good byte, held until the next good frame
//   valid      high while data holds an unread byte
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    sticky; a byte was loaded while an unread byte was pending
//   busy       high whenever the receiver is not idle
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       res,
  input  logic       rx,
  input  logic       rd,
  output logic [6:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [6:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             sync1_q, sync2_q;
  logic             rxs;

  // Two-flop synchroniser; resets to the idle-high line level.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rxs = sync2_q;

  // State and datapath registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, bit timing, shift register and host handshake.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;

    // A read of a pending byte clears it; a load below takes precedence.
    if (rd && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d = '0;
          if (!rxs) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            // Line went high again before mid start bit: a glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d     = '0;
          shreg_d   = {rxs, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rxs) begin
            // Bit 7 is always 0 from the transmitter and is dropped.
            data_d  = shreg_q[6:0];
            valid_d = 1'b1;
            if (valid_q && !rd) begin
              overrun_d = 1'b1;
            end
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BRK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BRK: begin
        // Hold here until the line returns high so a stuck-low line cannot retrigger.
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx with CLKS_PER_BIT=16: directed frames, scoreboard
// queue of expected loads, and a monitor that checks each load as it appears.
module tb_uart_rx;

  localparam int unsigned CPB = 16;

  logic       clk;
  logic       res;
  logic       rx;
  logic       rd;
  logic [6:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  typedef struct packed {
    logic [6:0] d;
    logic       ov;
    int         due;
  } exp_t;

  exp_t exp_q[$];

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int fe_cnt  = 0;
  logic auto_rd = 1'b0;
  logic man_rd  = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .res       (res),
    .rx        (rx),
    .rd        (rd),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Host reader: auto-acknowledges valid, or pulses rd on request.
  initial begin
    rd = 1'b0;
    forever begin
      @(negedge clk);
      rd = (auto_rd && valid && !rd) || man_rd;
    end
  end

  // Monitor: a load is valid rising or data changing while valid stays high.
  initial begin
    logic       pv;
    logic [6:0] pd;
    logic       pfe;
    exp_t       e;
    pv  = 1'b0;
    pd  = '0;
    pfe = 1'b0;
    forever begin
      @(negedge clk);
      if (frame_err) begin
        fe_cnt = fe_cnt + 1;
        if (pfe) chk("frame_err_one_cycle", 1, 0);
      end
      if (valid && (!pv || data != pd)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_load", int'(data), 32'hFFFF);
        end else begin
          e = exp_q.pop_front();
          chk("load_data", int'(data), int'(e.d));
          chk("load_overrun", int'(overrun), int'(e.ov));
          chk("load_latency", int'((cyc >= e.due - 2) && (cyc <= e.due + 2)), 1);
        end
      end
      pv  = valid;
      pd  = data;
      pfe = frame_err;
    end
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input logic exp_ov);
    exp_t e;
    rx = 1'b0;
    if (stop) begin
      e.d   = b[6:0];
      e.ov  = exp_ov;
      e.due = cyc + 155;
      exp_q.push_back(e);
    end
    idle(CPB);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] partial;
    res = 1'b1;
    rx  = 1'b1;
    idle(3);
    chk("reset_data", int'(data), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);
    res = 1'b0;
    idle(5);

    // Ideal frame, acknowledged.
    auto_rd = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(10);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_valid_after_rd", int'(valid), 0);

    // Back-to-back frames, each acknowledged.
    send_frame(8'h41, 1'b1, 1'b0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(10);
    chk("t2_overrun", int'(overrun), 0);
    chk("t2_no_frame_err", fe_cnt, 0);

    // Overrun: two frames with no read.
    auto_rd = 1'b0;
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h34, 1'b1, 1'b1);
    idle(5);
    chk("t3_data", int'(data), 'h34);
    chk("t3_valid", int'(valid), 1);
    chk("t3_overrun", int'(overrun), 1);
    man_rd = 1'b1;
    idle(1);
    man_rd = 1'b0;
    chk("t3_valid_after_rd", int'(valid), 0);
    chk("t3_overrun_after_rd", int'(overrun), 0);
    idle(5);

    // Framing error with a held-low line, then recovery.
    auto_rd = 1'b1;
    send_frame(8'h12, 1'b1, 1'b0);
    idle(5);
    send_frame(8'h33, 1'b0, 1'b0);
    rx = 1'b0;
    idle(40);
    chk("t4_frame_err_count", fe_cnt, 1);
    chk("t4_data_held", int'(data), 'h12);
    chk("t4_valid_held", int'(valid), 0);
    chk("t4_busy_in_break", int'(busy), 1);
    rx = 1'b1;
    idle(10);
    chk("t4_idle_after_break", int'(busy), 0);
    send_frame(8'h21, 1'b1, 1'b0);
    idle(10);

    // Short low glitch on an idle line.
    rx = 1'b0;
    idle(5);
    rx = 1'b1;
    idle(3);
    chk("t5_busy_during_glitch", int'(busy), 1);
    idle(27);
    chk("t5_busy_after_glitch", int'(busy), 0);
    chk("t5_no_frame_err", fe_cnt, 1);

    // Reset in the middle of bit 4 of a frame.
    partial = 8'h5A;
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) send_bit(partial[i]);
    rx = partial[4];
    idle(CPB / 2);
    res = 1'b1;
    #1;
    chk("t6_reset_data", int'(data), 0);
    chk("t6_reset_valid", int'(valid), 0);
    chk("t6_reset_busy", int'(busy), 0);
    chk("t6_reset_overrun", int'(overrun), 0);
    chk("t6_reset_frame_err", int'(frame_err), 0);
    rx = 1'b1;
    idle(4);
    chk("t6_reset_held_busy", int'(busy), 0);
    res = 1'b0;
    idle(10);
    chk("t6_no_partial_load", int'(valid), 0);
    auto_rd = 1'b0;
    send_frame(8'h6A, 1'b1, 1'b0);
    idle(5);
    chk("t6_data", int'(data), 'h6A);
    chk("t6_valid", int'(valid), 1);

    idle(20);
    chk("all_expected_loads_seen", exp_q.size(), 0);
    chk("total_frame_errs", fe_cnt, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
